// File: rtl/cnn_conv1_acc_relu_if.sv
// Product-in / pixel-out handshake bundle for the conv1 accumulate/ReLU stage.
// The slave modport is the stage's own view; master is the upstream/consumer side.
interface cnn_conv1_acc_relu_if #(
   parameter int PROD_WIDTH = 24,
   parameter int BIAS_WIDTH = 14,
   parameter int OUT_WIDTH  = 14
);
   logic [PROD_WIDTH-1:0] prod_data;
   logic                  prod_last;
   logic                  prod_valid;
   logic                  prod_ready;
   logic [BIAS_WIDTH-1:0] bias;
   logic [OUT_WIDTH-1:0]  out_data;
   logic                  out_sat;
   logic                  out_valid;
   logic                  out_ready;
   logic                  err_last;

   modport slave (
      input  prod_data, prod_last, prod_valid, bias, out_ready,
      output prod_ready, out_data, out_sat, out_valid, err_last
   );

   modport master (
      output prod_data, prod_last, prod_valid, bias, out_ready,
      input  prod_ready, out_data, out_sat, out_valid, err_last
   );
endinterface

// File: rtl/cnn_conv1_acc_relu.sv
// Sums TAPS products plus bias, applies ReLU, >>> SHIFT and saturates; pixel is valid 1 cycle
// after the last tap, held in a one-entry register; prod_ready follows out_ready while it is full.
module cnn_conv1_acc_relu #(
   parameter int PROD_WIDTH = 24,
   parameter int BIAS_WIDTH = 14,
   parameter int ACC_WIDTH  = 28,
   parameter int TAPS       = 9,
   parameter int SHIFT      = 8,
   parameter int OUT_WIDTH  = 14
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   cnn_conv1_acc_relu_if.slave   io
);
   localparam int CNT_WIDTH = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);
   localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

   typedef enum logic {ST_ACC, ST_EMIT} state_t;

   state_t                        state_q, state_d;
   logic [CNT_WIDTH-1:0]          tap_cnt_q, tap_cnt_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
   logic                          out_sat_q, out_sat_d;
   logic                          out_valid_q, out_valid_d;
   logic                          err_last_q, err_last_d;

   logic                          prod_ready;
   logic                          accept;
   logic                          last_tap;
   logic signed [ACC_WIDTH-1:0]   prod_ext;
   logic signed [ACC_WIDTH-1:0]   bias_ext;
   logic signed [ACC_WIDTH-1:0]   sum;
   logic signed [ACC_WIDTH-1:0]   scaled;

   assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){io.prod_data[PROD_WIDTH-1]}}, io.prod_data};
   assign bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){io.bias[BIAS_WIDTH-1]}}, io.bias};

   always_comb begin
      state_d     = state_q;
      tap_cnt_d   = tap_cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_valid_d = out_valid_q;
      err_last_d  = err_last_q;

      prod_ready = (state_q == ST_ACC) ? 1'b1 : io.out_ready;
      accept     = io.prod_valid & prod_ready;
      last_tap   = (tap_cnt_q == LAST_TAP);
      // Tap 0 restarts from bias, so a stale acc never leaks into a new window.
      sum        = ((tap_cnt_q == '0) ? bias_ext : acc_q) + prod_ext;
      scaled     = sum >>> SHIFT;

      if (state_q == ST_EMIT && io.out_ready) begin
         out_valid_d = 1'b0;
         state_d     = ST_ACC;
      end

      if (accept) begin
         acc_d = sum;
         if (io.prod_last != last_tap) begin
            err_last_d = 1'b1;
         end
         if (last_tap) begin
            tap_cnt_d   = '0;
            out_valid_d = 1'b1;
            state_d     = ST_EMIT;
            if (sum[ACC_WIDTH-1]) begin
               out_data_d = '0;
               out_sat_d  = 1'b0;
            end else if (scaled > OUT_MAX) begin
               out_data_d = OUT_MAX[OUT_WIDTH-1:0];
               out_sat_d  = 1'b1;
            end else begin
               out_data_d = scaled[OUT_WIDTH-1:0];
               out_sat_d  = 1'b0;
            end
         end else begin
            tap_cnt_d = tap_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= ST_ACC;
         tap_cnt_q   <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
         err_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_cnt_q   <= tap_cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
         err_last_q  <= err_last_d;
      end
   end

   assign io.prod_ready = prod_ready;
   assign io.out_data   = out_data_q;
   assign io.out_sat    = out_sat_q;
   assign io.out_valid  = out_valid_q;
   assign io.err_last   = err_last_q;
endmodule

// File: tb/tb_cnn_conv1_acc_relu.sv
// Directed bench for cnn_conv1_acc_relu: hand-computed windows covering scaling, ReLU,
// saturation, output back-pressure, prod_last errors and mid-window reset.
module tb_cnn_conv1_acc_relu;
   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 ap_clk = ~ap_clk;

   cnn_conv1_acc_relu_if #(.PROD_WIDTH(24), .BIAS_WIDTH(14), .OUT_WIDTH(14)) bus ();

   cnn_conv1_acc_relu #(
      .PROD_WIDTH(24), .BIAS_WIDTH(14), .ACC_WIDTH(28),
      .TAPS(9), .SHIFT(8), .OUT_WIDTH(14)
   ) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .io     (bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Presents one product for exactly one clock edge; caller ensures prod_ready.
   task automatic tap(input int p, input logic lst, input int b);
      bus.prod_data  = 24'(p);
      bus.prod_last  = lst;
      bus.bias       = 14'(b);
      bus.prod_valid = 1'b1;
      @(posedge ap_clk);
      #1;
      bus.prod_valid = 1'b0;
      bus.prod_last  = 1'b0;
   endtask

   task automatic window(input int p, input int b);
      for (int i = 0; i < 9; i++) tap(p, (i == 8), b);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   initial begin
      bus.prod_data  = '0;
      bus.prod_last  = 1'b0;
      bus.prod_valid = 1'b0;
      bus.bias       = '0;
      bus.out_ready  = 1'b1;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;

      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_out_sat", int'(bus.out_sat), 0);
      chk("rst_err_last", int'(bus.err_last), 0);
      chk("rst_prod_ready", int'(bus.prod_ready), 1);

      // 9 x 256 = 2304, >>>8 = 9
      for (int i = 0; i < 8; i++) tap(256, 1'b0, 0);
      chk("t1_not_early", int'(bus.out_valid), 0);
      tap(256, 1'b1, 0);
      chk("t1_valid", int'(bus.out_valid), 1);
      chk("t1_data", int'(bus.out_data), 9);
      chk("t1_sat", int'(bus.out_sat), 0);
      idle(1);
      chk("t1_one_cycle", int'(bus.out_valid), 0);

      // 500 - 9000 < 0 -> ReLU clamps to 0
      window(-1000, 500);
      chk("t2_valid", int'(bus.out_valid), 1);
      chk("t2_data", int'(bus.out_data), 0);
      chk("t2_sat", int'(bus.out_sat), 0);
      chk("t2_err_clean", int'(bus.err_last), 0);
      idle(1);

      // 75505654 >>> 8 = 294943 -> clip to 8191
      window(8388607, 8191);
      chk("t3_data", int'(bus.out_data), 8191);
      chk("t3_sat", int'(bus.out_sat), 1);
      idle(1);

      // Back-pressure: pixel held, next tap stalled until out_ready rises.
      bus.out_ready = 1'b0;
      window(256, 0);
      chk("t4_valid", int'(bus.out_valid), 1);
      bus.prod_data  = 24'(512);
      bus.bias       = 14'(0);
      bus.prod_last  = 1'b0;
      bus.prod_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_ready", int'(bus.prod_ready), 0);
         idle(1);
         chk("t4_hold_data", int'(bus.out_data), 9);
         chk("t4_hold_valid", int'(bus.out_valid), 1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("t4_release_ready", int'(bus.prod_ready), 1);
      idle(1);
      bus.prod_valid = 1'b0;
      chk("t4_drained", int'(bus.out_valid), 0);
      // 512 taken as tap 0 above: 512 + 8*256 = 2560 -> 10
      for (int i = 0; i < 8; i++) tap(256, (i == 7), 0);
      chk("t4_next_valid", int'(bus.out_valid), 1);
      chk("t4_next_data", int'(bus.out_data), 10);
      idle(1);

      // prod_last asserted early on tap 5
      for (int i = 0; i < 9; i++) begin
         tap(256, (i == 5) || (i == 8), 0);
         if (i == 4) chk("t5_err_before", int'(bus.err_last), 0);
         if (i == 5) chk("t5_err_set", int'(bus.err_last), 1);
      end
      chk("t5_data", int'(bus.out_data), 9);
      chk("t5_valid", int'(bus.out_valid), 1);
      idle(3);
      chk("t5_err_sticky", int'(bus.err_last), 1);

      // Reset mid-window discards the partial sum and clears err_last.
      for (int i = 0; i < 4; i++) tap(100000, 1'b0, 1000);
      ap_rst = 1'b1;
      idle(1);
      ap_rst = 1'b0;
      chk("t6_rst_err", int'(bus.err_last), 0);
      chk("t6_rst_valid", int'(bus.out_valid), 0);
      window(256, 0);
      chk("t6_valid", int'(bus.out_valid), 1);
      chk("t6_data", int'(bus.out_data), 9);
      chk("t6_err", int'(bus.err_last), 0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
